// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor.
// Imported by the datapath, its register bank and the control unit.
package k_and_s_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NREG   = 4;
    localparam int RIDX_W = $clog2(NREG);

    typedef enum logic [4:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        ALU_OR  = 2'b00,
        ALU_ADD = 2'b01,
        ALU_SUB = 2'b10,
        ALU_AND = 2'b11
    } alu_op_t;

    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_BRANCH = 8'h00;
    localparam logic [7:0] OP_BZERO  = 8'h01;
    localparam logic [7:0] OP_BNZERO = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BNNEG  = 8'h04;
    localparam logic [7:0] OP_BOV    = 8'h05;
    localparam logic [7:0] OP_BNOV   = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    function automatic decoded_instruction_type decode_op(
        input logic [7:0] op
    );
        decoded_instruction_type t;
        t = I_NOP;
        case (op)
            OP_LOAD:   t = I_LOAD;
            OP_STORE:  t = I_STORE;
            OP_MOVE:   t = I_MOVE;
            OP_ADD:    t = I_ADD;
            OP_SUB:    t = I_SUB;
            OP_AND:    t = I_AND;
            OP_OR:     t = I_OR;
            OP_BRANCH: t = I_BRANCH;
            OP_BZERO:  t = I_BZERO;
            OP_BNZERO: t = I_BNZERO;
            OP_BNEG:   t = I_BNEG;
            OP_BNNEG:  t = I_BNNEG;
            OP_BOV:    t = I_BOV;
            OP_BNOV:   t = I_BNOV;
            OP_HALT:   t = I_HALT;
            default:   t = I_NOP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/register_bank.sv
// 4x16 general-purpose register bank.
// Three async read ports (ALU A/B, store data), one sync write port.
module register_bank
    import k_and_s_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] rd_a_idx_i,
    input  logic [RIDX_W-1:0] rd_b_idx_i,
    input  logic [RIDX_W-1:0] rd_c_idx_i,
    input  logic [RIDX_W-1:0] wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_en_i,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o,
    output logic [DATA_W-1:0] rd_c_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_a_o = regs_q[rd_a_idx_i];
    assign rd_b_o = regs_q[rd_b_idx_i];
    assign rd_c_o = regs_q[rd_c_idx_i];

endmodule

// File: rtl/data_path.sv
// K&S datapath: PC, IR, register bank, ALU and flags.
// Executes the per-cycle enables/selects issued by control_unit.
module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic              zero_q, neg_q, uov_q, sov_q;

    decoded_instruction_type dec;
    alu_op_t                 alu_op;

    logic [RIDX_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_a, rd_b, rd_c;
    logic [DATA_W-1:0] bus_a, bus_b;

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_out;
    logic              alu_uov, alu_sov;

    assign dec    = decode_op(ir_q[15:8]);
    assign alu_op = alu_op_t'(operation);

    assign pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            if (pc_enable) pc_q <= pc_d;
            if (ir_enable) ir_q <= data_in;
        end
    end

    assign wr_idx  = (dec == I_LOAD) ? ir_q[6:5] : ir_q[5:4];
    assign wr_data = c_sel ? alu_out : data_in;

    register_bank u_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_a_idx_i (ir_q[3:2]),
        .rd_b_idx_i (ir_q[1:0]),
        .rd_c_idx_i (ir_q[6:5]),
        .wr_idx_i   (wr_idx),
        .wr_data_i  (wr_data),
        .wr_en_i    (write_reg_enable),
        .rd_a_o     (rd_a),
        .rd_b_o     (rd_b),
        .rd_c_o     (rd_c)
    );

    // MOVE routes A onto both operands so OR produces a plain copy.
    assign bus_a = rd_a;
    assign bus_b = (dec == I_MOVE) ? rd_a : rd_b;

    assign sum  = {1'b0, bus_a} + {1'b0, bus_b};
    assign diff = {1'b0, bus_a} - {1'b0, bus_b};

    always_comb begin
        alu_out = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        unique case (alu_op)
            ALU_OR: begin
                alu_out = bus_a | bus_b;
            end
            ALU_ADD: begin
                alu_out = sum[DATA_W-1:0];
                alu_uov = sum[DATA_W];
                alu_sov = (bus_a[15] == bus_b[15])
                        && (sum[15] != bus_a[15]);
            end
            ALU_SUB: begin
                alu_out = diff[DATA_W-1:0];
                alu_uov = diff[DATA_W];
                alu_sov = (bus_a[15] != bus_b[15])
                        && (diff[15] != bus_a[15]);
            end
            ALU_AND: begin
                alu_out = bus_a & bus_b;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_q <= (alu_out == '0);
            neg_q  <= alu_out[DATA_W-1];
            uov_q  <= alu_uov;
            sov_q  <= alu_sov;
        end
    end

    assign decoded_instruction = dec;
    assign zero_op             = zero_q;
    assign neg_op              = neg_q;
    assign unsigned_overflow   = uov_q;
    assign signed_overflow     = sov_q;
    assign ram_addr            = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign data_out            = rd_c;

endmodule
